// File: rtl/axi_rdata_dispatch_if.sv
// Bundle of AXI R-channel, ID-FIFO head and decompressor read-data signals
// seen by the read-data dispatcher.
interface axi_rdata_dispatch_if #(
    parameter int NUM_DECOMPRESSOR = 2,
    parameter int DATA_WIDTH       = 512
);
    logic [DATA_WIDTH-1:0]       m_axi_rdata;
    logic                        m_axi_rvalid;
    logic                        m_axi_rlast;
    logic [1:0]                  m_axi_rresp;
    logic                        m_axi_rready;
    logic [NUM_DECOMPRESSOR-1:0] fifo_select;
    logic                        fifo_empty;
    logic                        fifo_rd_en;
    logic [DATA_WIDTH-1:0]       dec_data;
    logic                        dec_last;
    logic [NUM_DECOMPRESSOR-1:0] dec_valid;
    logic [NUM_DECOMPRESSOR-1:0] dec_ready;
    logic                        resp_err;
    logic                        sel_err;
    logic [15:0]                 burst_cnt;

    // Dispatcher side
    modport slave (
        input  m_axi_rdata, m_axi_rvalid, m_axi_rlast, m_axi_rresp,
        input  fifo_select, fifo_empty, dec_ready,
        output m_axi_rready, fifo_rd_en, dec_data, dec_last, dec_valid,
        output resp_err, sel_err, burst_cnt
    );

    // Environment side: AXI slave, ID FIFO and decompressors
    modport master (
        output m_axi_rdata, m_axi_rvalid, m_axi_rlast, m_axi_rresp,
        output fifo_select, fifo_empty, dec_ready,
        input  m_axi_rready, fifo_rd_en, dec_data, dec_last, dec_valid,
        input  resp_err, sel_err, burst_cnt
    );
endinterface

// File: rtl/axi_rdata_dispatch.sv
// Routes AXI read-data beats to the decompressor that owns the oldest
// outstanding burst, through a single skid-free output register.
module axi_rdata_dispatch #(
    parameter int NUM_DECOMPRESSOR = 2,
    parameter int DATA_WIDTH       = 512
) (
    input logic                  clk,
    input logic                  rst,
    axi_rdata_dispatch_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                      state, state_nxt;
    logic [NUM_DECOMPRESSOR-1:0] sel_q;
    logic                        rready, latch, accept, pop, drain;
    logic                        resp_err_q, sel_err_q;
    logic [15:0]                 burst_cnt_q;

    logic                        vld_p1;
    logic                        last_p1;
    logic [NUM_DECOMPRESSOR-1:0] owner_p1;
    logic [DATA_WIDTH-1:0]       data_p1;

    // An all-zero owner has no consumer, so its beats drain on their own.
    always_comb begin
        drain = vld_p1 & ((owner_p1 == '0) | (|(owner_p1 & bus.dec_ready)));
    end

    always_comb begin
        state_nxt = state;
        rready    = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    state_nxt = BURST;
                    latch     = 1'b1;
                end
            end
            BURST: begin
                rready = ~vld_p1 | drain;
                if (rready && bus.m_axi_rvalid && bus.m_axi_rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = bus.m_axi_rvalid & rready;
    assign pop    = accept & bus.m_axi_rlast & ~bus.fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= '0;
            sel_err_q   <= 1'b0;
            resp_err_q  <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            if (latch) begin
                sel_q <= bus.fifo_select;
                if (!$onehot(bus.fifo_select)) begin
                    sel_err_q <= 1'b1;
                end
            end
            if (accept && (bus.m_axi_rresp != 2'b00)) begin
                resp_err_q <= 1'b1;
            end
            if (accept && bus.m_axi_rlast) begin
                burst_cnt_q <= burst_cnt_q + 16'd1;
            end
        end
    end

    // Stage p1: output register, refilled on accept, emptied on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            owner_p1 <= '0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            last_p1  <= bus.m_axi_rlast;
            owner_p1 <= sel_q;
        end else if (drain) begin
            vld_p1   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1 <= bus.m_axi_rdata;
        end
    end

    assign bus.m_axi_rready = rready;
    assign bus.fifo_rd_en   = pop;
    assign bus.dec_data     = data_p1;
    assign bus.dec_last     = vld_p1 & last_p1;
    assign bus.dec_valid    = vld_p1 ? owner_p1 : '0;
    assign bus.resp_err     = resp_err_q;
    assign bus.sel_err      = sel_err_q;
    assign bus.burst_cnt    = burst_cnt_q;
endmodule

// File: tb/tb_axi_rdata_dispatch.sv
// Scoreboard bench for axi_rdata_dispatch: beats are queued as they are
// accepted and matched against the decompressor side as they drain.
module tb_axi_rdata_dispatch;
    localparam int ND = 2;
    localparam int DW = 512;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [ND-1:0] owner;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    axi_rdata_dispatch_if #(.NUM_DECOMPRESSOR(ND), .DATA_WIDTH(DW)) ifc ();

    axi_rdata_dispatch #(.NUM_DECOMPRESSOR(ND), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            exp_bursts = 0;
    beat_t         exp_q[$];
    logic [ND-1:0] id_q[$];
    beat_t         mon_e;
    bit            pop_pending = 0;

    function automatic logic [DW-1:0] mk(input int unsigned i);
        logic [31:0] w;
        w = (i * 32'h9E3779B1) ^ 32'hA5A50000;
        return {16{w}};
    endfunction

    task automatic fifo_refresh();
        ifc.fifo_empty  = (id_q.size() == 0);
        ifc.fifo_select = (id_q.size() != 0) ? id_q[0] : '0;
    endtask

    task automatic push_id(input logic [ND-1:0] s);
        @(negedge clk);
        id_q.push_back(s);
        fifo_refresh();
    endtask

    task automatic rvalid_off();
        @(negedge clk);
        ifc.m_axi_rvalid = 1'b0;
        ifc.m_axi_rlast  = 1'b0;
        ifc.m_axi_rresp  = 2'b00;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last,
                             input logic [1:0] resp, input logic [ND-1:0] own,
                             output int waits);
        bit done;
        done  = 0;
        waits = 0;
        while (!done && waits < 40) begin
            @(negedge clk);
            ifc.m_axi_rvalid = 1'b1;
            ifc.m_axi_rdata  = d;
            ifc.m_axi_rlast  = last;
            ifc.m_axi_rresp  = resp;
            #1;
            if (ifc.m_axi_rready) begin
                if (own != '0) exp_q.push_back('{d, last, own});
                if (last) exp_bursts++;
                n_checks++;
                if (ifc.fifo_rd_en !== last)
                    $display("FAIL fifo_rd_en_on_accept: got %0b required %0b", ifc.fifo_rd_en, last);
                else n_pass++;
                done = 1;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL beat_accept_timeout: rready stayed %0b required 1", ifc.m_axi_rready);
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            @(negedge clk);
            #2;
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: %0d beats outstanding required 0", name, exp_q.size());
        else n_pass++;
        n_checks++;
        if (ifc.burst_cnt !== 16'(exp_bursts))
            $display("FAIL %s_burst_cnt: got %0d required %0d", name, ifc.burst_cnt, exp_bursts);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++; if (ifc.m_axi_rready !== 1'b0) $display("FAIL rst_rready: got %0b required 0", ifc.m_axi_rready); else n_pass++;
        n_checks++; if (ifc.fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %0b required 0", ifc.fifo_rd_en); else n_pass++;
        n_checks++; if (ifc.dec_valid !== 2'b00) $display("FAIL rst_dec_valid: got %0b required 00", ifc.dec_valid); else n_pass++;
        n_checks++; if (ifc.dec_last !== 1'b0) $display("FAIL rst_dec_last: got %0b required 0", ifc.dec_last); else n_pass++;
        n_checks++; if (ifc.resp_err !== 1'b0) $display("FAIL rst_resp_err: got %0b required 0", ifc.resp_err); else n_pass++;
        n_checks++; if (ifc.sel_err !== 1'b0) $display("FAIL rst_sel_err: got %0b required 0", ifc.sel_err); else n_pass++;
        n_checks++; if (ifc.burst_cnt !== 16'd0) $display("FAIL rst_burst_cnt: got %0d required 0", ifc.burst_cnt); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        int w;
        ifc.dec_ready = 2'b11;
        push_id(2'b01);
        for (int i = 0; i < 4; i++) begin
            send_beat(mk(100 + i), (i == 3), 2'b00, 2'b01, w);
            if (i > 0) begin
                n_checks++;
                if (w !== 0) $display("FAIL single_throughput_beat%0d: waited %0d cycles required 0", i, w);
                else n_pass++;
            end
        end
        rvalid_off();
        #1;
        n_checks++; if (ifc.dec_valid !== 2'b01) $display("FAIL single_last_valid: got %0b required 01", ifc.dec_valid); else n_pass++;
        n_checks++; if (ifc.dec_last !== 1'b1) $display("FAIL single_last_flag: got %0b required 1", ifc.dec_last); else n_pass++;
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        int w;
        ifc.dec_ready = 2'b11;
        push_id(2'b01);
        push_id(2'b10);
        send_beat(mk(200), 1'b0, 2'b00, 2'b01, w);
        send_beat(mk(201), 1'b1, 2'b00, 2'b01, w);
        send_beat(mk(202), 1'b0, 2'b00, 2'b10, w);
        n_checks++; if (w !== 1) $display("FAIL b2b_idle_gap: waited %0d cycles required 1", w); else n_pass++;
        send_beat(mk(203), 1'b1, 2'b00, 2'b10, w);
        n_checks++; if (w !== 0) $display("FAIL b2b_beat4_wait: waited %0d cycles required 0", w); else n_pass++;
        rvalid_off();
        wait_drain("b2b");
    endtask

    task automatic test_backpressure();
        int w;
        ifc.dec_ready = 2'b11;
        push_id(2'b01);
        send_beat(mk(300), 1'b0, 2'b00, 2'b01, w);
        send_beat(mk(301), 1'b0, 2'b00, 2'b01, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifc.dec_ready    = 2'b00;
            ifc.m_axi_rvalid = 1'b1;
            ifc.m_axi_rdata  = mk(302);
            ifc.m_axi_rlast  = 1'b0;
            #1;
            n_checks++;
            if (ifc.m_axi_rready !== 1'b0) $display("FAIL stall_rready_c%0d: got %0b required 0", i, ifc.m_axi_rready);
            else n_pass++;
            n_checks++;
            if (ifc.dec_valid !== 2'b01) $display("FAIL stall_held_valid_c%0d: got %0b required 01", i, ifc.dec_valid);
            else n_pass++;
        end
        @(negedge clk);
        ifc.m_axi_rvalid = 1'b0;
        ifc.dec_ready    = 2'b11;
        send_beat(mk(302), 1'b0, 2'b00, 2'b01, w);
        send_beat(mk(303), 1'b1, 2'b00, 2'b01, w);
        rvalid_off();
        wait_drain("stall");
    endtask

    task automatic test_empty_stall();
        int w;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ifc.m_axi_rvalid = 1'b1;
            ifc.m_axi_rdata  = mk(400);
            ifc.m_axi_rlast  = 1'b1;
            #1;
            n_checks++;
            if (ifc.m_axi_rready !== 1'b0) $display("FAIL empty_rready_c%0d: got %0b required 0", i, ifc.m_axi_rready);
            else n_pass++;
            n_checks++;
            if (ifc.fifo_rd_en !== 1'b0) $display("FAIL empty_rd_en_c%0d: got %0b required 0", i, ifc.fifo_rd_en);
            else n_pass++;
        end
        rvalid_off();
        push_id(2'b10);
        send_beat(mk(401), 1'b0, 2'b00, 2'b10, w);
        send_beat(mk(402), 1'b1, 2'b00, 2'b10, w);
        rvalid_off();
        wait_drain("empty");
    endtask

    task automatic test_errors();
        int w;
        ifc.dec_ready = 2'b11;
        n_checks++; if (ifc.resp_err !== 1'b0) $display("FAIL err_resp_clean: got %0b required 0", ifc.resp_err); else n_pass++;
        n_checks++; if (ifc.sel_err !== 1'b0) $display("FAIL err_sel_clean: got %0b required 0", ifc.sel_err); else n_pass++;
        push_id(2'b01);
        send_beat(mk(500), 1'b0, 2'b10, 2'b01, w);
        send_beat(mk(501), 1'b1, 2'b00, 2'b01, w);
        rvalid_off();
        wait_drain("resp");
        n_checks++; if (ifc.resp_err !== 1'b1) $display("FAIL err_resp_set: got %0b required 1", ifc.resp_err); else n_pass++;
        push_id(2'b11);
        send_beat(mk(510), 1'b0, 2'b00, 2'b11, w);
        send_beat(mk(511), 1'b1, 2'b00, 2'b11, w);
        rvalid_off();
        wait_drain("sel11");
        n_checks++; if (ifc.sel_err !== 1'b1) $display("FAIL err_sel_set: got %0b required 1", ifc.sel_err); else n_pass++;
        n_checks++; if (ifc.resp_err !== 1'b1) $display("FAIL err_resp_sticky: got %0b required 1", ifc.resp_err); else n_pass++;
        push_id(2'b00);
        send_beat(mk(520), 1'b0, 2'b00, 2'b00, w);
        send_beat(mk(521), 1'b1, 2'b00, 2'b00, w);
        n_checks++; if (w !== 0) $display("FAIL zero_owner_wait: waited %0d cycles required 0", w); else n_pass++;
        rvalid_off();
        wait_drain("sel00");
    endtask

    task automatic test_reset_mid_burst();
        int w;
        ifc.dec_ready = 2'b11;
        push_id(2'b10);
        send_beat(mk(600), 1'b0, 2'b01, 2'b10, w);
        send_beat(mk(601), 1'b0, 2'b00, 2'b10, w);
        @(negedge clk);
        ifc.dec_ready = 2'b00;
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (ifc.dec_valid !== 2'b00) $display("FAIL mid_rst_dec_valid: got %0b required 00", ifc.dec_valid); else n_pass++;
        n_checks++; if (ifc.dec_last !== 1'b0) $display("FAIL mid_rst_dec_last: got %0b required 0", ifc.dec_last); else n_pass++;
        n_checks++; if (ifc.m_axi_rready !== 1'b0) $display("FAIL mid_rst_rready: got %0b required 0", ifc.m_axi_rready); else n_pass++;
        n_checks++; if (ifc.fifo_rd_en !== 1'b0) $display("FAIL mid_rst_rd_en: got %0b required 0", ifc.fifo_rd_en); else n_pass++;
        n_checks++; if (ifc.resp_err !== 1'b0) $display("FAIL mid_rst_resp_err: got %0b required 0", ifc.resp_err); else n_pass++;
        n_checks++; if (ifc.sel_err !== 1'b0) $display("FAIL mid_rst_sel_err: got %0b required 0", ifc.sel_err); else n_pass++;
        n_checks++; if (ifc.burst_cnt !== 16'd0) $display("FAIL mid_rst_burst_cnt: got %0d required 0", ifc.burst_cnt); else n_pass++;
        exp_q.delete();
        id_q.delete();
        fifo_refresh();
        exp_bursts = 0;
        ifc.m_axi_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ifc.dec_ready = 2'b11;
        push_id(2'b01);
        send_beat(mk(610), 1'b1, 2'b00, 2'b01, w);
        rvalid_off();
        wait_drain("post_rst");
    endtask

    initial begin
        ifc.m_axi_rdata  = '0;
        ifc.m_axi_rvalid = 1'b0;
        ifc.m_axi_rlast  = 1'b0;
        ifc.m_axi_rresp  = 2'b00;
        ifc.dec_ready    = 2'b00;
        fifo_refresh();
        #1;
        fork
            forever begin
                @(negedge clk);
                #1;
                if (!rst) begin
                    if (ifc.fifo_rd_en) begin
                        n_checks++;
                        if (ifc.fifo_empty !== 1'b0)
                            $display("FAIL rd_en_while_empty: fifo_empty=%0b required 0", ifc.fifo_empty);
                        else n_pass++;
                        pop_pending = 1;
                    end
                    if ((ifc.dec_valid & ifc.dec_ready) != '0) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL sb_unexpected_beat: dec_valid=%0b with none expected", ifc.dec_valid);
                        end else begin
                            mon_e = exp_q.pop_front();
                            if (ifc.dec_data !== mon_e.data || ifc.dec_last !== mon_e.last || ifc.dec_valid !== mon_e.owner)
                                $display("FAIL sb_beat: data=%0h last=%0b valid=%0b required data=%0h last=%0b valid=%0b",
                                         ifc.dec_data[31:0], ifc.dec_last, ifc.dec_valid,
                                         mon_e.data[31:0], mon_e.last, mon_e.owner);
                            else n_pass++;
                        end
                    end
                end
                if (pop_pending) begin
                    @(posedge clk);
                    #1;
                    if (!rst && id_q.size() != 0) void'(id_q.pop_front());
                    pop_pending = 0;
                    fifo_refresh();
                end
            end
        join_none
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_backpressure();
        test_empty_stall();
        test_errors();
        test_reset_mid_burst();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi_rdata_dispatch.md
AXI_RDATA_DISPATCH -- requirements
Module: axi_rdata_dispatch

Interface
REQ-001: Parameter NUM_DECOMPRESSOR, default 2, number of decompressor read-data consumers.
REQ-002: Parameter DATA_WIDTH, default 512, width of the AXI read-data beat.
REQ-003: clk  input  1  single clock for all logic.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: m_axi_rdata  input  DATA_WIDTH  AXI R-channel data.
REQ-006: m_axi_rvalid  input  1  AXI R-channel valid.
REQ-007: m_axi_rlast  input  1  last beat of the burst.
REQ-008: m_axi_rresp  input  2  AXI read response.
REQ-009: m_axi_rready  output  1  AXI R-channel ready.
REQ-010: fifo_select  input  NUM_DECOMPRESSOR  one-hot owner of the oldest outstanding burst, from the ID FIFO head.
REQ-011: fifo_empty  input  1  ID FIFO empty.
REQ-012: fifo_rd_en  output  1  pop the ID FIFO head.
REQ-013: dec_data  output  DATA_WIDTH  beat to the decompressors, shared bus.
REQ-014: dec_last  output  1  beat is the last of its burst.
REQ-015: dec_valid  output  NUM_DECOMPRESSOR  per-decompressor beat valid.
REQ-016: dec_ready  input  NUM_DECOMPRESSOR  per-decompressor ready.
REQ-017: resp_err  output  1  sticky flag: non-OKAY rresp seen.
REQ-018: sel_err  output  1  sticky flag: non-one-hot fifo_select latched.
REQ-019: burst_cnt  output  16  completed bursts, wraps at 0xFFFF->0.

Function
REQ-020: The FSM shall have two states, IDLE and BURST.
REQ-021: IDLE->BURST shall occur when fifo_empty=0, latching fifo_select into sel_q on the same edge.
REQ-022: m_axi_rready shall be 0 in IDLE, so no beat is accepted without a known owner.
REQ-023: In BURST, m_axi_rready shall be (out_valid=0) OR (the held beat is drained this cycle).
REQ-024: A beat is accepted when m_axi_rvalid & m_axi_rready; it shall load a single output register {data, last, owner=sel_q} on that edge.
REQ-025: Latency: accepted at edge N -> presented on dec_* from cycle N+1; sustained throughput is one beat/cycle when the owner holds dec_ready=1.
REQ-026: dec_valid shall equal out_owner when out_valid=1, else all zero.
REQ-027: The held beat drains when |(dec_valid & dec_ready); simultaneous drain and accept replaces the register with no bubble.
REQ-028: Accepting a beat with m_axi_rlast=1 shall pulse fifo_rd_en for exactly that cycle (combinational with the handshake), return to IDLE, and increment burst_cnt.
REQ-029: After the rlast beat, IDLE->BURST for the next burst may occur one cycle later; the previous burst's held beat keeps its own owner.
REQ-030: fifo_rd_en shall never assert while fifo_empty=1.
REQ-031: A beat accepted with rresp!=0 shall set resp_err; the beat is still forwarded.
REQ-032: Latching a fifo_select with popcount!=1 shall set sel_err; the burst is still consumed and popped; all-zero owner drops beats without backpressure.
REQ-033: m_axi_rvalid in IDLE with fifo_empty=1 shall be stalled indefinitely (rready=0).

Reset
REQ-034: On rst, asynchronously: state=IDLE, out_valid=0, dec_valid=0, dec_last=0, m_axi_rready=0, fifo_rd_en=0, resp_err=0, sel_err=0, burst_cnt=0; dec_data is don't-care.
REQ-035: Reset mid-burst shall discard the held beat and partial burst; the ID FIFO is reset on the same reset.

Verification
REQ-036: FIFO holds owner 2'b01, 4-beat burst, dec_ready=1 -> dec_valid=01 on 4 consecutive cycles starting one cycle after first accept, dec_last on beat 4, one fifo_rd_en pulse, burst_cnt=1.
REQ-037: Owners 01 then 10, back-to-back 2-beat bursts -> beats 1-2 on dec_valid[0], beats 3-4 on dec_valid[1], two fifo_rd_en pulses, burst_cnt=2.
REQ-038: dec_ready[0]=0 for 3 cycles mid-burst -> m_axi_rready=0 those cycles, no beat lost or duplicated, data order preserved.
REQ-039: rvalid=1 with fifo_empty=1 for 10 cycles -> m_axi_rready=0 throughout, fifo_rd_en=0; FIFO push then burst proceeds normally.
REQ-040: Beat with rresp=2'b10 -> resp_err=1 and stays 1 until rst; owner 2'b11 latched -> sel_err=1.
REQ-041: rst asserted mid-burst between edges -> all outputs at reset values immediately, before the next clk edge.
